// File: rtl/scan_digit_rx.sv
// scan_digit_rx: receives the time-multiplexed {digit, select} scan bus and rebuilds a parallel value
//   Ports: clk, rst (sync, active-high); scan_d/scan_an asynchronous scan bus;
//   value = last complete frame (digit k at [4k+3:4k]); value_valid / value_changed /
//   frame_err are 1-cycle pulses; locked is high between a full frame and the next error.
//   Optional macro SCAN_SEG_EN adds seg[6:0] = {g..a}, active-low hex decode of value[3:0].
module scan_digit_rx #(
    parameter int DIGITS     = 2,
    parameter int SEL_W      = 3,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            scan_d,
    input  logic [SEL_W-1:0]      scan_an,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    output logic                  value_changed,
    output logic                  frame_err,
    output logic                  locked
`ifdef SCAN_SEG_EN
    ,output logic [6:0]           seg
`endif
);
    localparam int BW = SEL_W + 4;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam int EW = $clog2(DIGITS);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic {HUNT, COLLECT} state_t;
    logic [BW-1:0] s1, s2, dat;
    logic [CW-1:0] cnt;
    logic accept;
    state_t st, st_n;
    logic [EW-1:0] expect_idx, exp_n;
    logic [DIGITS-1:0][3:0] shadow, sh_n;
    logic [4*DIGITS-1:0] val_n;
    logic vv_n, vc_n, fe_n, lk_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [SEL_W-1:0] a;
    logic [3:0] d;
    // dat holds the synced sample that cnt+1 consecutive samples have agreed on;
    // cnt saturates above the accept point so a steady bus accepts only once
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= '0;
            s2  <= '0;
            dat <= '0;
            cnt <= '0;
        end else begin
            s1  <= {scan_an, scan_d};
            s2  <= s1;
            dat <= s2;
            cnt <= (s2 != dat) ? '0 : (cnt == CW'(STABLE_CYC)) ? cnt : cnt + CW'(1);
        end
    end
    assign accept = (cnt == CW'(STABLE_CYC - 1));
    assign a = dat[BW-1:4];
    assign d = dat[3:0];
    always_comb begin
        st_n  = st;
        exp_n = expect_idx;
        sh_n  = shadow;
        val_n = value;
        vv_n  = 1'b0;
        vc_n  = 1'b0;
        fe_n  = 1'b0;
        lk_n  = locked;
        tmo_n = (st == COLLECT) ? tmo + TW'(1) : '0;
        if (accept) begin
            tmo_n = '0;
            if (st == HUNT) begin
                if (a == '0) begin
                    sh_n    = '0;
                    sh_n[0] = d;
                    exp_n   = EW'(1);
                    st_n    = COLLECT;
                end
            end else if (a == SEL_W'(expect_idx)) begin
                sh_n[expect_idx] = d;
                if (expect_idx == EW'(DIGITS - 1)) begin
                    val_n = sh_n;
                    vv_n  = 1'b1;
                    vc_n  = (sh_n != value);
                    lk_n  = 1'b1;
                    exp_n = '0;
                end else begin
                    exp_n = expect_idx + EW'(1);
                end
            end else begin
                // out-of-order digit: drop the partial frame; a fresh digit 0 restarts it
                fe_n = 1'b1;
                lk_n = 1'b0;
                sh_n = '0;
                if (a == '0) begin
                    sh_n[0] = d;
                    exp_n   = EW'(1);
                end else begin
                    exp_n = '0;
                    st_n  = HUNT;
                end
            end
        end else if (st == COLLECT && tmo == TW'(TIMEOUT - 1)) begin
            fe_n  = 1'b1;
            lk_n  = 1'b0;
            st_n  = HUNT;
            exp_n = '0;
            tmo_n = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= HUNT;
            expect_idx    <= '0;
            shadow        <= '0;
            value         <= '0;
            value_valid   <= 1'b0;
            value_changed <= 1'b0;
            frame_err     <= 1'b0;
            locked        <= 1'b0;
            tmo           <= '0;
        end else begin
            st            <= st_n;
            expect_idx    <= exp_n;
            shadow        <= sh_n;
            value         <= val_n;
            value_valid   <= vv_n;
            value_changed <= vc_n;
            frame_err     <= fe_n;
            locked        <= lk_n;
            tmo           <= tmo_n;
        end
    end
`ifdef SCAN_SEG_EN
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    always_ff @(posedge clk) begin
        if (rst) seg <= 7'h7F;
        else     seg <= HEX[val_n[3:0]];
    end
`endif
endmodule
